cb_arb: RTL and testbench
=========================

CB_ARB -- requirements
Module: cb_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the circular buffer insert ports.
REQ-002 Parameter CB_IDX, default 3, circular buffer index width (depth 2**CB_IDX).
REQ-003 Parameter CB_WIDTH, default 8, entry data width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester insert request, level; bit i = requester i.
REQ-007 req_data  input  NREQ*CB_WIDTH  insert data; slice i = requester i.
REQ-008 flush  input  1  single-cycle rollback command.
REQ-009 flush_offset  input  CB_IDX  tail rollback distance for the buffer.
REQ-010 cb_full  input  1  buffer full flag.
REQ-011 cb_full_almost  input  1  buffer has exactly one free entry.
REQ-012 gnt  output  NREQ  per-requester grant, same cycle as accepted req; one-hot or two-hot.
REQ-013 din1_en, din2_en  output  1 each  buffer insert enables.
REQ-014 din1, din2  output  CB_WIDTH each  buffer insert data.
REQ-015 move_tail  output  1  buffer tail rollback strobe.
REQ-016 tail_offset  output  CB_IDX  buffer tail rollback distance.

Function
REQ-017 gnt, din*_en, din*, move_tail, tail_offset are combinational from inputs and registered state; buffer samples them at the next rising edge.
REQ-018 Grant capacity per cycle: 0 if cb_full, 1 if cb_full_almost (and not cb_full), else 2.
REQ-019 Requesters scanned round-robin from registered pointer rr_ptr, wrapping NREQ-1 to 0.
REQ-020 First granted requester drives din1/din1_en; second drives din2/din2_en; din2_en never asserted without din1_en.
REQ-021 Unused din ports drive 0 with enable 0.
REQ-022 gnt[i] asserted only if req[i]; never more than capacity bits set.
REQ-023 rr_ptr updates to (last granted index + 1) mod NREQ; unchanged when no grant.
REQ-024 FSM states RUN, FLUSH, HOLD; grants only in RUN.
REQ-025 RUN with flush=1: no grants that cycle, move_tail=1, tail_offset=flush_offset, next state HOLD.
REQ-026 HOLD: no grants, move_tail=0; next state RUN unless flush=1 (then same action as REQ-025, stay HOLD).
REQ-027 FLUSH state entered only via REQ-025 alternate path is not used; FLUSH reserved as encoding for one-cycle registered rollback when flush arrives and decode is registered-implemented; implementations with combinational rollback SHALL still encode and never enter it.
REQ-028 move_tail=0 and tail_offset=0 whenever no flush action occurs.
REQ-029 flush overrides all pending requests in the same cycle; requesters must hold req until gnt.
REQ-030 cb_full and cb_full_almost both high treated as full (capacity 0).

Reset
REQ-031 reset asserted: state=RUN, rr_ptr=0 immediately, independent of clk.
REQ-032 During reset: gnt=0, din*_en=0, din*=0, move_tail=0, tail_offset=0.
REQ-033 Reset mid-flush abandons rollback; first cycle after deassertion is RUN with rr_ptr=0.

Structure
REQ-034 Shared package holds FSM state encoding (RUN, FLUSH, HOLD) and default CB_IDX/CB_WIDTH constants.
REQ-035 One sub-module: rr_pick2 -- combinational rotating two-winner priority picker (inputs req, rr_ptr, capacity; outputs two indices and valids).

Verification
REQ-036 req=4'b1111, ptr=0, not full -> gnt=0011, din1=data0, din2=data1; next cycle gnt=1100, ptr=0.
REQ-037 req=4'b1001, ptr=1 -> gnt=1001, din1=data3, din2=data0 (wrap), ptr becomes 1.
REQ-038 cb_full_almost=1, req=1111, ptr=2 -> gnt=0100, din2_en=0, ptr=3; cb_full=1 -> gnt=0000, ptr unchanged.
REQ-039 flush=1, flush_offset=3, req=1111 -> gnt=0, move_tail=1, tail_offset=3; next cycle gnt=0 (HOLD); following cycle grants resume.
REQ-040 flush held 2 cycles -> move_tail=1 both cycles, grants resume only one cycle after flush drops.
REQ-041 Assert reset during HOLD with ptr=2 -> outputs 0 immediately; after release, req=1111 yields gnt=0011.

Source files
------------

// File: rtl/cb_arb_pkg.sv
// Shared definitions for the circular-buffer insert arbiter.
package cb_arb_pkg;

  // Default geometry of the circular buffer being fed.
  localparam int CB_IDX_DEF   = 3;
  localparam int CB_WIDTH_DEF = 8;

  // Arbiter control states. FLUSH is a reserved encoding for a registered
  // rollback variant; this implementation rolls back combinationally and
  // never enters it.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } cb_state_e;

  // Number of inserts the buffer can take this cycle. Full wins over
  // almost-full when both are raised.
  function automatic logic [1:0] insert_capacity(input logic full,
                                                 input logic full_almost);
    if (full)             return 2'd0;
    else if (full_almost) return 2'd1;
    else                  return 2'd2;
  endfunction

endpackage

// File: rtl/cb_arb_rr_pick2.sv
// Rotating priority picker that selects up to two requesters, scanning
// upward from rr_ptr and wrapping NREQ-1 to 0. Purely combinational.
module cb_arb_rr_pick2
  import cb_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  input  logic [1:0]      cap,
  output logic [PW-1:0]   idx1,
  output logic            vld1,
  output logic [PW-1:0]   idx2,
  output logic            vld2
);

  // Walk requesters in rotated order; first hit takes slot 1, second slot 2.
  always_comb begin
    int j;
    vld1 = 1'b0;
    vld2 = 1'b0;
    idx1 = '0;
    idx2 = '0;
    j    = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        if (!vld1 && (cap >= 2'd1)) begin
          vld1 = 1'b1;
          idx1 = PW'(j);
        end else if (vld1 && !vld2 && (cap >= 2'd2)) begin
          vld2 = 1'b1;
          idx2 = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/cb_arb.sv
// Arbiter granting up to two requesters per cycle into the circular buffer's
// dual insert ports, with flush-driven tail rollback.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal arbitration; flush triggers rollback and goes HOLD
// ST_HOLD  | one quiet cycle after rollback; repeated flush stays here
// ST_FLUSH | reserved encoding, never entered (falls back to RUN)
module cb_arb
  import cb_arb_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int CB_IDX   = CB_IDX_DEF,
  parameter int CB_WIDTH = CB_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CB_WIDTH-1:0] req_data,
  input  logic                     flush,
  input  logic [CB_IDX-1:0]        flush_offset,
  input  logic                     cb_full,
  input  logic                     cb_full_almost,
  output logic [NREQ-1:0]          gnt,
  output logic                     din1_en,
  output logic                     din2_en,
  output logic [CB_WIDTH-1:0]      din1,
  output logic [CB_WIDTH-1:0]      din2,
  output logic                     move_tail,
  output logic [CB_IDX-1:0]        tail_offset
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  cb_state_e           state, state_nxt;
  logic [PW-1:0]       rr_ptr, rr_ptr_nxt;
  logic                grant_en;
  logic [1:0]          pick_cap;
  logic [PW-1:0]       idx1, idx2;
  logic                vld1, vld2;
  logic [CB_WIDTH-1:0] data_arr [NREQ];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    else                     return i + 1'b1;
  endfunction

  // State and round-robin pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_RUN;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Next state, rollback strobe and grant permission; reset silences all.
  always_comb begin
    state_nxt   = state;
    move_tail   = 1'b0;
    tail_offset = '0;
    grant_en    = 1'b0;
    case (state)
      ST_RUN: begin
        if (flush) begin
          move_tail   = 1'b1;
          tail_offset = flush_offset;
          state_nxt   = ST_HOLD;
        end else begin
          grant_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          move_tail   = 1'b1;
          tail_offset = flush_offset;
          state_nxt   = ST_HOLD;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if (reset) begin
      move_tail   = 1'b0;
      tail_offset = '0;
      grant_en    = 1'b0;
    end
  end

  // Capacity offered to the picker; zero whenever grants are blocked.
  always_comb begin
    pick_cap = grant_en ? insert_capacity(cb_full, cb_full_almost) : 2'd0;
  end

  cb_arb_rr_pick2 #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .cap    (pick_cap),
    .idx1   (idx1),
    .vld1   (vld1),
    .idx2   (idx2),
    .vld2   (vld2)
  );

  // Split the flat data bus into per-requester slices.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      data_arr[i] = req_data[i*CB_WIDTH +: CB_WIDTH];
    end
  end

  // Grant vector and insert port muxing; idle ports drive zero.
  always_comb begin
    gnt     = '0;
    din1_en = vld1;
    din2_en = vld2;
    din1    = '0;
    din2    = '0;
    if (vld1) begin
      gnt[idx1] = 1'b1;
      din1      = data_arr[idx1];
    end
    if (vld2) begin
      gnt[idx2] = 1'b1;
      din2      = data_arr[idx2];
    end
  end

  // Pointer moves just past the last winner in scan order.
  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (vld2)      rr_ptr_nxt = ptr_inc(idx2);
    else if (vld1) rr_ptr_nxt = ptr_inc(idx1);
  end

endmodule

// File: tb/tb_cb_arb.sv
// Directed bench for cb_arb: expected outputs are queued as each step is
// driven and popped for comparison mid-cycle.
module tb_cb_arb;

  localparam int NREQ = 4;
  localparam int CB_IDX = 3;
  localparam int CB_WIDTH = 8;

  typedef struct packed {
    logic [3:0] gnt;
    logic       e1;
    logic [7:0] d1;
    logic       e2;
    logic [7:0] d2;
    logic       mt;
    logic [2:0] to;
  } out_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NREQ-1:0]          req;
  logic [NREQ*CB_WIDTH-1:0] req_data;
  logic                     flush;
  logic [CB_IDX-1:0]        flush_offset;
  logic                     cb_full;
  logic                     cb_full_almost;
  logic [NREQ-1:0]          gnt;
  logic                     din1_en, din2_en;
  logic [CB_WIDTH-1:0]      din1, din2;
  logic                     move_tail;
  logic [CB_IDX-1:0]        tail_offset;

  int errors = 0;
  int checks = 0;
  out_t  sb_q[$];
  string tag_q[$];
  logic [7:0] dv [NREQ];

  cb_arb #(.NREQ(NREQ), .CB_IDX(CB_IDX), .CB_WIDTH(CB_WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_data       (req_data),
    .flush          (flush),
    .flush_offset   (flush_offset),
    .cb_full        (cb_full),
    .cb_full_almost (cb_full_almost),
    .gnt            (gnt),
    .din1_en        (din1_en),
    .din2_en        (din2_en),
    .din1           (din1),
    .din2           (din2),
    .move_tail      (move_tail),
    .tail_offset    (tail_offset)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [3:0] g, input logic e1, input logic [7:0] d1,
                              input logic e2, input logic [7:0] d2,
                              input logic mt, input logic [2:0] to);
    out_t o;
    o.gnt = g; o.e1 = e1; o.d1 = d1; o.e2 = e2; o.d2 = d2; o.mt = mt; o.to = to;
    return o;
  endfunction

  // Drive inputs (called at posedge+1) and queue the expected response.
  task automatic drive(input string tag, input logic [3:0] r, input logic fl,
                       input logic [2:0] off, input logic full, input logic alm,
                       input out_t e);
    req = r; flush = fl; flush_offset = off; cb_full = full; cb_full_almost = alm;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Pop the oldest expectation and compare against current outputs.
  task automatic check_now();
    out_t  o, e;
    string t;
    o = mk(gnt, din1_en, din1, din2_en, din2, move_tail, tail_offset);
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty obs=%h", o);
      return;
    end
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs gnt=%b e1=%b d1=%h e2=%b d2=%h mt=%b to=%0d exp gnt=%b e1=%b d1=%h e2=%b d2=%h mt=%b to=%0d",
             t, o.gnt, o.e1, o.d1, o.e2, o.d2, o.mt, o.to,
             e.gnt, e.e1, e.d1, e.e2, e.d2, e.mt, e.to);
    end
  endtask

  // One cycle: drive after the edge, check at the falling edge, advance.
  task automatic step(input string tag, input logic [3:0] r, input logic fl,
                      input logic [2:0] off, input logic full, input logic alm,
                      input out_t e);
    drive(tag, r, fl, off, full, alm, e);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  out_t zero;

  initial begin
    zero = mk(4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0);
    for (int i = 0; i < NREQ; i++) begin
      dv[i] = 8'(8'h11 * (i + 1)) ^ 8'($urandom_range(0, 15) << 4);
      req_data[i*CB_WIDTH +: CB_WIDTH] = dv[i];
    end
    reset = 1'b1;
    req = '0; flush = 1'b0; flush_offset = '0; cb_full = 1'b0; cb_full_almost = 1'b0;

    // Reset active with requests present: everything quiet.
    #2;
    step("reset_quiet", 4'b1111, 1'b0, 3'd5, 1'b0, 1'b0, zero);
    step("reset_flush_quiet", 4'b1111, 1'b1, 3'd5, 1'b0, 1'b0, zero);
    reset = 1'b0;

    step("all_req_p0", 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, mk(4'b0011, 1, dv[0], 1, dv[1], 0, 0));
    step("all_req_p2", 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, mk(4'b1100, 1, dv[2], 1, dv[3], 0, 0));
    step("single_r0", 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0, mk(4'b0001, 1, dv[0], 0, 8'h00, 0, 0));
    step("wrap_1001_p1", 4'b1001, 1'b0, 3'd0, 1'b0, 1'b0, mk(4'b1001, 1, dv[3], 1, dv[0], 0, 0));
    step("single_r1", 4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, mk(4'b0010, 1, dv[1], 0, 8'h00, 0, 0));
    step("almost_p2", 4'b1111, 1'b0, 3'd0, 1'b0, 1'b1, mk(4'b0100, 1, dv[2], 0, 8'h00, 0, 0));
    step("full_p3", 4'b1111, 1'b0, 3'd0, 1'b1, 1'b0, zero);
    step("full_and_almost", 4'b1111, 1'b0, 3'd0, 1'b1, 1'b1, zero);
    step("after_full_p3", 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, mk(4'b1001, 1, dv[3], 1, dv[0], 0, 0));
    step("no_req", 4'b0000, 1'b0, 3'd6, 1'b0, 1'b0, zero);
    step("sparse_0101_p1", 4'b0101, 1'b0, 3'd0, 1'b0, 1'b0, mk(4'b0101, 1, dv[2], 1, dv[0], 0, 0));

    // Single-cycle flush, HOLD, then grants resume.
    step("flush_run", 4'b1111, 1'b1, 3'd3, 1'b0, 1'b0, mk(4'b0000, 0, 8'h00, 0, 8'h00, 1, 3'd3));
    step("hold_quiet", 4'b1111, 1'b0, 3'd7, 1'b0, 1'b0, zero);
    step("resume_p1", 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, mk(4'b0110, 1, dv[1], 1, dv[2], 0, 0));

    // Flush held two cycles.
    step("flush2_a", 4'b1111, 1'b1, 3'd5, 1'b0, 1'b0, mk(4'b0000, 0, 8'h00, 0, 8'h00, 1, 3'd5));
    step("flush2_b_hold", 4'b1111, 1'b1, 3'd2, 1'b0, 1'b0, mk(4'b0000, 0, 8'h00, 0, 8'h00, 1, 3'd2));
    step("flush2_hold_quiet", 4'b1111, 1'b0, 3'd2, 1'b0, 1'b0, zero);
    step("flush2_resume_p3", 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, mk(4'b1001, 1, dv[3], 1, dv[0], 0, 0));

    // Park pointer at 2, flush into HOLD, then reset asynchronously.
    step("single_r1_b", 4'b0010, 1'b0, 3'd0, 1'b0, 1'b0, mk(4'b0010, 1, dv[1], 0, 8'h00, 0, 0));
    step("flush_to_hold", 4'b0000, 1'b1, 3'd1, 1'b0, 1'b0, mk(4'b0000, 0, 8'h00, 0, 8'h00, 1, 3'd1));
    drive("reset_in_hold", 4'b1111, 1'b1, 3'd4, 1'b0, 1'b0, zero);
    #1;
    reset = 1'b1;
    #1;
    check_now();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_reset_p0", 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, mk(4'b0011, 1, dv[0], 1, dv[1], 0, 0));

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover obs=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
